// File: rtl/rv32_pkg.sv
// Shared RV32I encoding definitions: opcodes, formats, request payload and
// the format decoder used by the instruction packer.
package rv32_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned OPC_W = 7;
   localparam int unsigned REG_W = 5;
   localparam int unsigned F3_W  = 3;
   localparam int unsigned F7_W  = 7;

   localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
   localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
   localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
   localparam logic [OPC_W-1:0] OP_REG    = 7'b0110011;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_e;

   typedef enum logic {ST_EMPTY, ST_FULL} state_e;

   typedef struct packed {
      logic [OPC_W-1:0] opcode;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [F3_W-1:0]  funct3;
      logic [F7_W-1:0]  funct7;
      logic [XLEN-1:0]  imm;
   } enc_req_t;

   // Major opcode to instruction format; unknown opcodes map to FMT_BAD.
   function automatic fmt_e decode_fmt(input logic [OPC_W-1:0] opcode);
      fmt_e fmt;
      case (opcode)
         OP_LUI, OP_AUIPC:         fmt = FMT_U;
         OP_JAL:                   fmt = FMT_J;
         OP_JALR, OP_LOAD, OP_IMM: fmt = FMT_I;
         OP_BRANCH:                fmt = FMT_B;
         OP_STORE:                 fmt = FMT_S;
         OP_REG:                   fmt = FMT_R;
         default:                  fmt = FMT_BAD;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Loader-side request and imem-side response bundle of the instruction encoder.
interface instr_encoder_if #(
   parameter int unsigned ADDR_W = 32
);
   logic                         in_valid;
   logic                         in_ready;
   logic [rv32_pkg::OPC_W-1:0]   opcode;
   logic [rv32_pkg::REG_W-1:0]   rd;
   logic [rv32_pkg::REG_W-1:0]   rs1;
   logic [rv32_pkg::REG_W-1:0]   rs2;
   logic [rv32_pkg::F3_W-1:0]    funct3;
   logic [rv32_pkg::F7_W-1:0]    funct7;
   logic [rv32_pkg::XLEN-1:0]    imm;
   logic                         out_valid;
   logic                         out_ready;
   logic [rv32_pkg::XLEN-1:0]    out_instr;
   logic [ADDR_W-1:0]            out_addr;
   logic                         imm_err;

   modport master (
      output in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
      input  in_ready, out_valid, out_instr, out_addr, imm_err
   );

   modport slave (
      input  in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
      output in_ready, out_valid, out_instr, out_addr, imm_err
   );
endinterface

// File: rtl/instr_pack.sv
// Combinational RV32I packer: scatters the immediate into the format's bit
// positions and flags immediates the format cannot represent.
module instr_pack
   import rv32_pkg::*;
(
   input  enc_req_t          i_req,
   output logic [XLEN-1:0]   o_instr,
   output logic              o_err
);

   fmt_e            w_fmt;
   logic [XLEN-1:0] w_imm;
   logic [XLEN-1:0] w_raw;
   logic            w_bad;
   logic            w_shift;

   assign w_fmt   = decode_fmt(i_req.opcode);
   assign w_imm   = i_req.imm;
   assign w_shift = (i_req.opcode == OP_IMM) && (i_req.funct3[1:0] == 2'b01);

   // Range checks are sign-extension checks on the 32-bit immediate.
   always_comb begin
      w_raw = NOP_INSTR;
      w_bad = 1'b0;
      case (w_fmt)
         FMT_U: begin
            w_raw = {w_imm[31:12], i_req.rd, i_req.opcode};
            w_bad = |w_imm[11:0];
         end
         FMT_J: begin
            w_raw = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], i_req.rd, i_req.opcode};
            w_bad = (w_imm[31:20] != {12{w_imm[20]}}) | w_imm[0];
         end
         FMT_I: begin
            if (w_shift) begin
               w_raw = {i_req.funct7, w_imm[4:0], i_req.rs1, i_req.funct3, i_req.rd, i_req.opcode};
               w_bad = |w_imm[31:5];
            end else begin
               w_raw = {w_imm[11:0], i_req.rs1, i_req.funct3, i_req.rd, i_req.opcode};
               w_bad = (w_imm[31:11] != {21{w_imm[11]}});
            end
         end
         FMT_S: begin
            w_raw = {w_imm[11:5], i_req.rs2, i_req.rs1, i_req.funct3, w_imm[4:0], i_req.opcode};
            w_bad = (w_imm[31:11] != {21{w_imm[11]}});
         end
         FMT_B: begin
            w_raw = {w_imm[12], w_imm[10:5], i_req.rs2, i_req.rs1, i_req.funct3,
                     w_imm[4:1], w_imm[11], i_req.opcode};
            w_bad = (w_imm[31:12] != {20{w_imm[12]}}) | w_imm[0];
         end
         FMT_R: begin
            w_raw = {i_req.funct7, i_req.rs2, i_req.rs1, i_req.funct3, i_req.rd, i_req.opcode};
            w_bad = 1'b0;
         end
         default: begin
            w_raw = NOP_INSTR;
            w_bad = 1'b1;
         end
      endcase
   end

   assign o_err   = w_bad;
   assign o_instr = w_bad ? NOP_INSTR : w_raw;

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: one-entry registered output stage that tags each
// packed word with a sequential imem address and counts illegal immediates.
module instr_encoder
   import rv32_pkg::*;
#(
   parameter int unsigned           ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]     BASE_ADDR = '0,
   parameter int unsigned           ERR_CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_clear,
   instr_encoder_if.slave           bus,
   output logic [ERR_CNT_W-1:0]     o_err_count
);

   state_e                r_state;
   state_e                w_state_nxt;
   logic                  w_in_ready;
   logic                  w_in_fire;
   logic                  w_out_fire;

   enc_req_t              w_req;
   logic [XLEN-1:0]       w_instr;
   logic                  w_err;
   logic [ADDR_W-1:0]     w_pc_base;

   logic [XLEN-1:0]       r_instr;
   logic [ADDR_W-1:0]     r_addr;
   logic                  r_err;
   logic [ADDR_W-1:0]     r_pc;
   logic [ERR_CNT_W-1:0]  r_err_cnt;

   assign w_req = '{opcode: bus.opcode, rd: bus.rd, rs1: bus.rs1, rs2: bus.rs2,
                    funct3: bus.funct3, funct7: bus.funct7, imm: bus.imm};

   instr_pack u_pack (
      .i_req   (w_req),
      .o_instr (w_instr),
      .o_err   (w_err)
   );

   // State register: FULL means the output register holds an unaccepted word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_EMPTY;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: if (w_in_fire)                w_state_nxt = ST_FULL;
         ST_FULL:  if (w_out_fire && !w_in_fire) w_state_nxt = ST_EMPTY;
         default:                                w_state_nxt = ST_EMPTY;
      endcase
   end

   always_comb begin
      w_in_ready = 1'b0;
      w_out_fire = 1'b0;
      case (r_state)
         ST_EMPTY: w_in_ready = 1'b1;
         ST_FULL: begin
            w_in_ready = bus.out_ready;
            w_out_fire = bus.out_ready;
         end
         default: w_in_ready = 1'b0;
      endcase
      w_in_fire = bus.in_valid & w_in_ready;
   end

   // A clear in the accepting cycle addresses the accepted word at the base.
   assign w_pc_base = i_clear ? BASE_ADDR : r_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr <= '0;
         r_addr  <= BASE_ADDR;
         r_err   <= 1'b0;
         r_pc    <= BASE_ADDR;
      end else begin
         if (w_in_fire) begin
            r_instr <= w_instr;
            r_addr  <= w_pc_base;
            r_err   <= w_err;
            r_pc    <= w_pc_base + ADDR_W'(4);
         end else if (i_clear) begin
            r_pc    <= BASE_ADDR;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_cnt <= '0;
      end else if (i_clear) begin
         r_err_cnt <= ERR_CNT_W'(w_in_fire & w_err);
      end else if (w_in_fire && w_err && (r_err_cnt != '1)) begin
         r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = (r_state == ST_FULL);
   assign bus.out_instr = r_instr;
   assign bus.out_addr  = r_addr;
   assign bus.imm_err   = r_err;
   assign o_err_count   = r_err_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: driver pushes expectations from an
// arithmetic reference model, a negedge monitor pops and compares.
module tb_instr_encoder;
   import rv32_pkg::*;

   localparam int unsigned ADDR_W = 32;
   localparam logic [31:0] BASE   = 32'h0;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_clear = 1'b0;
   logic [7:0] err_count;

   instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

   instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .ERR_CNT_W(8)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clear     (i_clear),
      .bus         (bus.slave),
      .o_err_count (err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
      logic        err;
      bit          gold_i;
      logic [31:0] g_instr;
      bit          gold_a;
      logic [31:0] g_addr;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] m_pc = BASE;
   int          m_errc = 0;
   int          ready_mode = 1;
   int          bnd[17] = '{2047, 2048, -2048, -2049, 31, 32, 4094, 4096, -4096, -4098,
                            1048574, 1048576, -1048576, -1048578, 32'h12345000, 0, -1};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
      end
   endtask

   // Reference model: legality by integer range, fields placed per format table.
   function automatic exp_t model(input enc_req_t r);
      exp_t   e;
      longint s;
      bit     ok;
      s = $signed(r.imm);
      e = '{default: 0};
      ok = 1'b1;
      case (r.opcode)
         OP_LUI, OP_AUIPC: begin
            ok = (s % 4096) == 0;
            e.instr = {r.imm[31:12], r.rd, r.opcode};
         end
         OP_JAL: begin
            ok = (s >= -(64'sd1 << 20)) && (s < (64'sd1 << 20)) && ((s % 2) == 0);
            e.instr = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, r.opcode};
         end
         OP_JALR, OP_LOAD: begin
            ok = (s >= -2048) && (s <= 2047);
            e.instr = {r.imm[11:0], r.rs1, r.funct3, r.rd, r.opcode};
         end
         OP_IMM: begin
            if (r.funct3 == 3'b001 || r.funct3 == 3'b101) begin
               ok = (s >= 0) && (s <= 31);
               e.instr = {r.funct7, r.imm[4:0], r.rs1, r.funct3, r.rd, r.opcode};
            end else begin
               ok = (s >= -2048) && (s <= 2047);
               e.instr = {r.imm[11:0], r.rs1, r.funct3, r.rd, r.opcode};
            end
         end
         OP_BRANCH: begin
            ok = (s >= -4096) && (s < 4096) && ((s % 2) == 0);
            e.instr = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.funct3, r.imm[4:1], r.imm[11], r.opcode};
         end
         OP_STORE: begin
            ok = (s >= -2048) && (s <= 2047);
            e.instr = {r.imm[11:5], r.rs2, r.rs1, r.funct3, r.imm[4:0], r.opcode};
         end
         OP_REG: e.instr = {r.funct7, r.rs2, r.rs1, r.funct3, r.rd, r.opcode};
         default: ok = 1'b0;
      endcase
      if (!ok) e.instr = 32'h0000_0013;
      e.err = !ok;
      return e;
   endfunction

   function automatic enc_req_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] imm);
      enc_req_t r;
      r.opcode = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
      r.funct3 = f3; r.funct7 = f7; r.imm = imm;
      return r;
   endfunction

   function automatic enc_req_t rand_req();
      logic [6:0] ops[10];
      enc_req_t   r;
      ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, 7'h00};
      r = mk(ops[$urandom_range(0, 9)], 5'($urandom), 5'($urandom), 5'($urandom),
             3'($urandom), 7'($urandom), 32'($urandom));
      if (r.opcode == 7'h00) r.opcode = 7'($urandom);
      case ($urandom_range(0, 3))
         0: r.imm = 32'($urandom);
         1: r.imm = 32'($signed($urandom_range(0, 80)) - 40);
         2: r.imm = 32'(bnd[$urandom_range(0, 16)]);
         default: r.imm = 32'($signed($urandom_range(0, 16383)) - 8192) & ~32'(1);
      endcase
      return r;
   endfunction

   // Drive one request at posedge+2; returns at posedge+2 after acceptance.
   task automatic send(input enc_req_t r, input bit clr, input bit gi, input logic [31:0] gins,
                       input bit ga, input logic [31:0] gadr);
      bit   fire;
      exp_t e;
      bus.opcode = r.opcode; bus.rd = r.rd; bus.rs1 = r.rs1; bus.rs2 = r.rs2;
      bus.funct3 = r.funct3; bus.funct7 = r.funct7; bus.imm = r.imm;
      bus.in_valid = 1'b1;
      i_clear = clr;
      fire = 1'b0;
      for (int c = 0; c < 200 && !fire; c++) begin
         @(negedge clk);
         fire = bus.in_ready;
         @(posedge clk);
         if (fire) begin
            e = model(r);
            e.addr = clr ? BASE : m_pc;
            m_pc = e.addr + 32'd4;
            if (clr) m_errc = e.err ? 1 : 0;
            else if (e.err && m_errc != 255) m_errc++;
            e.gold_i = gi; e.g_instr = gins; e.gold_a = ga; e.g_addr = gadr;
            q.push_back(e);
         end else if (clr) begin
            m_pc = BASE;
            m_errc = 0;
         end
         #2;
      end
      if (!fire) begin
         checks++; failures++;
         $display("FAIL in_accept_timeout actual=not_accepted required=accepted");
      end
      bus.in_valid = 1'b0;
      i_clear = 1'b0;
   endtask

   task automatic idle_check(input string name, input logic [31:0] act_sel, input logic [31:0] req);
      chk(name, act_sel, req);
   endtask

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       bus.out_ready = 1'b1;
         1:       bus.out_ready = 1'b0;
         default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: every valid word must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_output actual=%h required=none", bus.out_instr);
         end else begin
            chk("out_instr", bus.out_instr, q[0].instr);
            chk("out_addr", bus.out_addr, q[0].addr);
            chk("imm_err", 32'(bus.imm_err), 32'(q[0].err));
            if (q[0].gold_i) chk("gold_instr", bus.out_instr, q[0].g_instr);
            if (q[0].gold_a) chk("gold_addr", bus.out_addr, q[0].g_addr);
            if (bus.out_ready) void'(q.pop_front());
         end
      end
   end

   initial begin
      enc_req_t r;
      bus.in_valid = 1'b0; bus.opcode = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0;
      bus.funct3 = '0; bus.funct7 = '0; bus.imm = '0; bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_out_instr", bus.out_instr, 32'h0);
      chk("rst_out_addr", bus.out_addr, BASE);
      chk("rst_imm_err", 32'(bus.imm_err), 32'h0);
      chk("rst_err_count", 32'(err_count), 32'h0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
      rst_n = 1'b1;
      ready_mode = 0;
      repeat (2) @(posedge clk);
      #2;

      send(mk(OP_IMM, 1, 0, 0, 0, 0, 32'hFFFF_FFFF), 0, 1, 32'hFFF0_0093, 1, 32'h0);
      @(negedge clk);
      chk("latency_out_valid", 32'(bus.out_valid), 32'h1);
      @(posedge clk); #2;

      send(mk(OP_BRANCH, 0, 1, 2, 0, 0, 32'hFFFF_FFFC), 1, 1, 32'hFE20_8EE3, 1, 32'h0);
      send(mk(OP_STORE, 0, 2, 5, 2, 0, 32'd8), 0, 1, 32'h0051_2423, 1, 32'h4);
      send(mk(OP_JAL, 1, 0, 0, 0, 0, 32'd8), 0, 1, 32'h0080_00EF, 1, 32'h8);
      send(mk(OP_LUI, 5, 0, 0, 0, 0, 32'h1234_5000), 0, 1, 32'h1234_52B7, 1, 32'hC);
      send(mk(OP_IMM, 1, 0, 0, 0, 0, 32'd2048), 0, 1, 32'h0000_0013, 1, 32'h10);
      send(mk(OP_JAL, 1, 0, 0, 0, 0, 32'd3), 0, 1, 32'h0000_0013, 1, 32'h14);
      send(mk(OP_LUI, 5, 0, 0, 0, 0, 32'h1), 0, 1, 32'h0000_0013, 1, 32'h18);
      @(negedge clk);
      idle_check("err_count_three", 32'(err_count), 32'd3);
      @(posedge clk); #2;

      // Backpressure: second word must wait while the first is held.
      ready_mode = 1;
      @(posedge clk); #2;
      send(mk(OP_REG, 3, 4, 5, 0, 7'h20, 32'h0), 0, 1, 32'h4052_01B3, 1, 32'h1C);
      fork
         send(mk(OP_IMM, 6, 7, 0, 3'b101, 7'h20, 32'd31), 0, 1, 32'h41F3_D313, 1, 32'h20);
         begin
            repeat (5) begin
               @(negedge clk);
               chk("hold_in_ready", 32'(bus.in_ready), 32'h0);
            end
            ready_mode = 0;
         end
      join
      repeat (3) @(posedge clk); #2;

      for (int i = 0; i < 3; i++) send(rand_req(), 0, 0, 0, 0, 0);
      r = rand_req();
      send(r, 1, 0, 0, 1, 32'h0);
      send(rand_req(), 0, 0, 0, 1, 32'h4);

      ready_mode = 2;
      for (int i = 0; i < 400; i++) begin
         send(rand_req(), ($urandom_range(0, 24) == 0), 0, 0, 0, 0);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #2;
         end
      end
      ready_mode = 0;
      repeat (4) @(posedge clk); #2;
      @(negedge clk);
      chk("err_count_random", 32'(err_count), 32'(m_errc));
      @(posedge clk); #2;

      send(mk(7'h7F, 0, 0, 0, 0, 0, 32'h0), 1, 1, 32'h0000_0013, 1, 32'h0);
      @(negedge clk);
      chk("err_count_clear_err", 32'(err_count), 32'd1);
      @(posedge clk); #2;
      for (int i = 0; i < 259; i++) send(mk(7'h7F, 0, 0, 0, 0, 0, 32'h0), 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("err_count_saturate", 32'(err_count), 32'd255);
      @(posedge clk); #2;
      send(mk(OP_REG, 1, 2, 3, 0, 0, 32'h0), 1, 0, 0, 1, 32'h0);
      @(negedge clk);
      chk("err_count_clear", 32'(err_count), 32'd0);
      @(posedge clk); #2;

      // Async reset while the output register is full.
      ready_mode = 1;
      @(posedge clk); #2;
      send(mk(OP_LOAD, 8, 9, 0, 2, 0, 32'hFFFF_F800), 0, 0, 0, 1, 32'h4);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("async_rst_out_addr", bus.out_addr, BASE);
      chk("async_rst_err_count", 32'(err_count), 32'h0);
      q.delete();
      m_pc = BASE;
      m_errc = 0;
      ready_mode = 0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #2;
      send(mk(OP_JALR, 1, 2, 0, 0, 0, 32'd2047), 0, 1, 32'h7FF1_00E7, 1, 32'h0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
